// File: rtl/msx_io_pkg.sv
// Shared types and helpers for the MSX joystick-port mouse emulation.
package msx_io_pkg;

  typedef enum logic [1:0] {
    NX_H = 2'd0,
    NX_L = 2'd1,
    NY_H = 2'd2,
    NY_L = 2'd3
  } nibble_state_t;

  localparam logic signed [7:0] MSX_MOUSE_MAX = 8'sh7F;
  localparam logic signed [7:0] MSX_MOUSE_MIN = 8'sh80;

  // Clamp a 10-bit intermediate sum to the 8-bit range the MSX protocol can carry.
  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    logic signed [9:0] hi;
    logic signed [9:0] lo;
    hi = {2'b00, MSX_MOUSE_MAX};
    lo = {2'b11, MSX_MOUSE_MIN};
    if (v > hi) begin
      sat8 = MSX_MOUSE_MAX;
    end else if (v < lo) begin
      sat8 = MSX_MOUSE_MIN;
    end else begin
      sat8 = v[7:0];
    end
  endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// One motion axis: saturating accumulator plus the snapshot read out by the
// nibble sequence. A packet arriving with a snapshot is folded into the fresh count.
module mouse_axis_acc
  import msx_io_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic signed [9:0] delta,
  input  logic              snap_take,
  output logic signed [7:0] acc,
  output logic signed [7:0] snap
);

  logic signed [7:0] acc_q, acc_d;
  logic signed [7:0] snap_q, snap_d;
  logic signed [9:0] base_s;
  logic signed [9:0] sum_s;

  always_comb begin
    base_s = 10'sd0;
    sum_s  = 10'sd0;
    snap_d = snap_q;
    if (snap_take) begin
      base_s = 10'sd0;
      snap_d = acc_q;
    end else begin
      base_s = {{2{acc_q[7]}}, acc_q};
      snap_d = snap_q;
    end
    if (pkt_valid) begin
      sum_s = base_s + delta;
    end else begin
      sum_s = base_s;
    end
    acc_d = sat8(sum_s);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_q  <= 8'sd0;
      snap_q <= 8'sd0;
    end else begin
      acc_q  <= acc_d;
      snap_q <= snap_d;
    end
  end

  assign acc  = acc_q;
  assign snap = snap_q;

endmodule

// File: rtl/msx_mouse_port.sv
// PS/2 mouse packets to MSX joystick-port mouse nibbles, clocked by the PSG
// strobe; also arbitrates mouse versus joystick ownership of the port.
module msx_mouse_port
  import msx_io_pkg::*;
#(
  parameter int CLK_HZ     = 21477270,
  parameter int TIMEOUT_US = 1500
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic        strobe,
  input  logic        joy_activity,
  output logic [5:0]  data,
  output logic        use_mouse
);

  localparam int TO_CNT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int CW     = $clog2(TO_CNT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TO_CNT);

  logic s1_q, s2_q, s3_q;
  logic tog_q;
  nibble_state_t state_q, state_d, cur_state_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] data_q, data_d;
  logic use_mouse_q, use_mouse_d;
  logic edge_s, pkt_s, expired_s, snap_take_s;
  logic signed [9:0] delta_x_s, delta_y_s;
  logic signed [7:0] acc_x, acc_y, snap_x, snap_y;
  logic unused_bits;

  // While in reset the synchroniser is preloaded so no phantom edge follows release.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_q <= strobe;
      s2_q <= strobe;
      s3_q <= strobe;
    end else begin
      s1_q <= strobe;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Tracks the packet toggle continuously so a stale toggle never counts as a packet.
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_mouse[24];
  end

  assign edge_s      = s2_q ^ s3_q;
  assign pkt_s       = ps2_mouse[24] ^ tog_q;
  assign expired_s   = (cnt_q == TO_MAX);
  assign cur_state_s = expired_s ? NX_H : state_q;
  assign snap_take_s = edge_s && (cur_state_s == NX_H);

  // MSX counts positive motion to the left, the opposite of PS/2 X.
  assign delta_x_s = -$signed({ps2_mouse[4], ps2_mouse[4], ps2_mouse[15:8]});
  assign delta_y_s = $signed({ps2_mouse[5], ps2_mouse[5], ps2_mouse[23:16]});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    use_mouse_d = use_mouse_q;
    if (edge_s) begin
      cnt_d = '0;
      case (cur_state_s)
        NX_H: begin
          data_d[3:0] = acc_x[7:4];
          state_d     = NX_L;
        end
        NX_L: begin
          data_d[3:0] = snap_x[3:0];
          state_d     = NY_H;
        end
        NY_H: begin
          data_d[3:0] = snap_y[7:4];
          state_d     = NY_L;
        end
        NY_L: begin
          data_d[3:0] = snap_y[3:0];
          state_d     = NX_H;
        end
        default: begin
          data_d[3:0] = 4'hF;
          state_d     = NX_H;
        end
      endcase
    end else if (expired_s) begin
      state_d = NX_H;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (pkt_s) begin
      data_d[5:4] = ~ps2_mouse[1:0];
    end else begin
      data_d[5:4] = data_q[5:4];
    end
    if (joy_activity) begin
      use_mouse_d = 1'b0;
    end else if (pkt_s) begin
      use_mouse_d = 1'b1;
    end else begin
      use_mouse_d = use_mouse_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= NX_H;
      cnt_q       <= TO_MAX;
      data_q      <= 6'b111111;
      use_mouse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      use_mouse_q <= use_mouse_d;
    end
  end

  mouse_axis_acc u_acc_x (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pkt_valid (pkt_s),
    .delta     (delta_x_s),
    .snap_take (snap_take_s),
    .acc       (acc_x),
    .snap      (snap_x)
  );

  mouse_axis_acc u_acc_y (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pkt_valid (pkt_s),
    .delta     (delta_y_s),
    .snap_take (snap_take_s),
    .acc       (acc_y),
    .snap      (snap_y)
  );

  // X high comes straight from the accumulator as it is captured; Y is read later.
  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2], acc_y, snap_x[7:4]};

  assign data      = data_q;
  assign use_mouse = use_mouse_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
// Directed bench for msx_mouse_port: a cycle-level model of the port protocol is
// compared every cycle, plus literal nibble expectations for each scenario.
`timescale 1ns/1ps
module tb_msx_mouse_port;

  localparam int TO_CNT = 21477270 / 1000000 * 1500;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic        strobe;
  logic        joy_activity;
  logic [5:0]  data;
  logic        use_mouse;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model state
  longint m_cyc = 0;
  longint m_last_edge = -1000000;
  int m_acc_x = 0, m_acc_y = 0, m_snap_x = 0, m_snap_y = 0;
  int m_idx = 0;
  int m_nib = 15;
  logic [1:0] m_btn = 2'b00;
  bit m_use = 1'b0;
  bit m_pend1 = 1'b0, m_pend2 = 1'b0;
  logic m_strobe_prev = 1'b0;
  logic m_tog_prev = 1'b0;

  always #23 clk_sys = ~clk_sys;

  msx_mouse_port dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_mouse    (ps2_mouse),
    .strobe       (strobe),
    .joy_activity (joy_activity),
    .data         (data),
    .use_mouse    (use_mouse)
  );

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Behavioural model: an edge takes effect 2 clocks after it is first sampled,
  // a packet on the clock where its toggle is first seen.
  always @(posedge clk_sys) begin
    bit edge_now;
    bit pkt;
    int dx, dy;
    m_cyc = m_cyc + 1;
    if (reset) begin
      m_acc_x = 0; m_acc_y = 0; m_snap_x = 0; m_snap_y = 0;
      m_idx = 0; m_nib = 15; m_btn = 2'b00; m_use = 1'b0;
      m_pend1 = 1'b0; m_pend2 = 1'b0;
      m_strobe_prev = strobe; m_tog_prev = ps2_mouse[24];
      m_last_edge = -1000000;
    end else begin
      edge_now = m_pend2;
      m_pend2 = m_pend1;
      m_pend1 = (strobe != m_strobe_prev);
      m_strobe_prev = strobe;
      pkt = (ps2_mouse[24] != m_tog_prev);
      m_tog_prev = ps2_mouse[24];
      if (edge_now) begin
        if (m_cyc - m_last_edge > TO_CNT) m_idx = 0;
        case (m_idx)
          0: begin
            m_nib = (m_acc_x & 255) >> 4;
            m_snap_x = m_acc_x; m_snap_y = m_acc_y;
            m_acc_x = 0; m_acc_y = 0;
          end
          1: m_nib = m_snap_x & 15;
          2: m_nib = (m_snap_y & 255) >> 4;
          default: m_nib = m_snap_y & 15;
        endcase
        m_idx = (m_idx + 1) % 4;
        m_last_edge = m_cyc;
      end
      if (pkt) begin
        dx = ps2_mouse[4] ? int'(ps2_mouse[15:8]) - 256 : int'(ps2_mouse[15:8]);
        dy = ps2_mouse[5] ? int'(ps2_mouse[23:16]) - 256 : int'(ps2_mouse[23:16]);
        m_acc_x = clamp(m_acc_x - dx);
        m_acc_y = clamp(m_acc_y + dy);
        m_btn = ps2_mouse[1:0];
      end
      if (joy_activity) m_use = 1'b0;
      else if (pkt) m_use = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_sys) begin
    logic [5:0] exp_data;
    if (chk_en) begin
      exp_data = {~m_btn[1], ~m_btn[0], 4'(m_nib)};
      n_assert = n_assert + 1;
      if (data !== exp_data || use_mouse !== m_use) begin
        n_fail = n_fail + 1;
        $display("FAIL model_cycle t=%0t data=%b use_mouse=%b expected data=%b use_mouse=%b",
                 $time, data, use_mouse, exp_data, m_use);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_assert = n_assert + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_packet(input int dx, input int dy, input logic [1:0] btn);
    logic [8:0] x9;
    logic [8:0] y9;
    x9 = 9'(dx);
    y9 = 9'(dy);
    ps2_mouse = {~ps2_mouse[24], y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 2'b00, btn};
  endtask

  task automatic packet(input int dx, input int dy, input logic [1:0] btn);
    drive_packet(dx, dy, btn);
    tick(2);
  endtask

  task automatic do_edge(input string name, input logic [3:0] exp_nib);
    strobe = ~strobe;
    tick(3);
    check_lit(name, {2'b00, data[3:0]}, {2'b00, exp_nib});
    tick(5);
  endtask

  initial begin
    reset = 1'b1;
    strobe = 1'b0;
    ps2_mouse = '0;
    joy_activity = 1'b0;
    tick(3);
    check_lit("reset_data", data, 6'b111111);
    check_lit("reset_use", {5'd0, use_mouse}, 6'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    tick(2);

    // dx=+5, dy=+3 -> X=0xFB, Y=0x03, then an empty sequence
    packet(5, 3, 2'b00);
    check_lit("use_after_pkt", {5'd0, use_mouse}, 6'd1);
    do_edge("t1_xh", 4'hF); do_edge("t1_xl", 4'hB);
    do_edge("t1_yh", 4'h0); do_edge("t1_yl", 4'h3);
    do_edge("t1b_xh", 4'h0); do_edge("t1b_xl", 4'h0);
    do_edge("t1b_yh", 4'h0); do_edge("t1b_yl", 4'h0);

    // three dx=-100 packets saturate X at +127
    packet(-100, 0, 2'b00); packet(-100, 0, 2'b00); packet(-100, 0, 2'b00);
    do_edge("sat_xh", 4'h7); do_edge("sat_xl", 4'hF);
    do_edge("sat_yh", 4'h0); do_edge("sat_yl", 4'h0);

    // two edges, long idle with motion, then restart at X high
    do_edge("to_a", 4'h0); do_edge("to_b", 4'h0);
    tick(10);
    packet(-16, 0, 2'b00);
    tick(34400);
    do_edge("to_xh", 4'h1); do_edge("to_xl", 4'h0);
    do_edge("to_yh", 4'h0); do_edge("to_yl", 4'h0);

    // dx=+1 packet coincident with the NX_H edge lands in the next snapshot
    strobe = ~strobe;
    tick(2);
    drive_packet(1, 0, 2'b00);
    tick(1);
    check_lit("same_xh", {2'b00, data[3:0]}, 6'h00);
    tick(5);
    do_edge("same_xl", 4'h0); do_edge("same_yh", 4'h0); do_edge("same_yl", 4'h0);
    do_edge("next_xh", 4'hF); do_edge("next_xl", 4'hF);
    do_edge("next_yh", 4'h0); do_edge("next_yl", 4'h0);

    // buttons and arbitration
    packet(0, 0, 2'b01);
    check_lit("left_btn", {4'd0, data[5:4]}, 6'b000010);
    check_lit("use_left", {5'd0, use_mouse}, 6'd1);
    joy_activity = 1'b1;
    tick(2);
    check_lit("joy_clear", {5'd0, use_mouse}, 6'd0);
    joy_activity = 1'b0;
    tick(2);
    joy_activity = 1'b1;
    packet(0, 0, 2'b00);
    check_lit("joy_wins", {5'd0, use_mouse}, 6'd0);
    check_lit("btn_release", {4'd0, data[5:4]}, 6'b000011);
    joy_activity = 1'b0;
    tick(2);

    // reset after NY_H discards pending motion
    packet(5, 0, 2'b10);
    do_edge("rst_xh", 4'hF); do_edge("rst_xl", 4'hB); do_edge("rst_yh", 4'h0);
    packet(20, 20, 2'b00);
    reset = 1'b1;
    tick(2);
    check_lit("rst_mid_data", data, 6'b111111);
    check_lit("rst_mid_use", {5'd0, use_mouse}, 6'd0);
    reset = 1'b0;
    tick(2);
    do_edge("post_rst_xh", 4'h0);
    do_edge("post_rst_xl", 4'h0);

    tick(5);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
